// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Command/result bundle between a requester and the bit-serial adder
// controller.
//   start     requester -> controller  operation request
//   a, b      requester -> controller  operands, sampled on accepted start
//   carry_in  requester -> controller  initial carry, sampled on accepted start
//   busy      controller -> requester  high while bits are being processed
//   done      controller -> requester  one-cycle completion pulse
//   sum       controller -> requester  last completed WIDTH-bit sum
//   carry_out controller -> requester  carry out of the MSB of last add
//   overflow  controller -> requester  signed overflow of last add
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller. One 1-bit full-adder slice is reused once per
// clock, LSB first, to add two WIDTH-bit operands plus a carry-in. Results
// (sum, carry_out, signed overflow) are registered and only change on the
// edge that completes an operation.
//   clk   in  system clock, all state on rising edge
//   rst   in  synchronous active-high reset
//   bus   slave side of serial_add_ctrl_if (start/a/b/carry_in in,
//         busy/done/sum/carry_out/overflow out)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_ctrl_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-adder slice helpers.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             overflow_r;

    logic             slice_sum_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_bit_s;
    logic             accept_s;

    // Adder slice, shifted accumulator and control decodes.
    always_comb begin
        slice_sum_s  = fa_sum(opa_r[0], opb_r[0], carry_r);
        slice_cout_s = fa_carry(opa_r[0], opb_r[0], carry_r);
        acc_next_s   = {slice_sum_s, acc_r[WIDTH-1:1]};
        last_bit_s   = (cnt_r == CNT_LAST);
        // start is only honoured outside RUN; a request during RUN is dropped.
        accept_s     = bus.start && (state_r != ST_RUN);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            opa_r       <= {WIDTH{1'b0}};
            opb_r       <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // Status flags are decoded from the next state so they line up
            // with the state they describe.
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
            if (accept_s) begin
                opa_r   <= bus.a;
                opb_r   <= bus.b;
                carry_r <= bus.carry_in;
                acc_r   <= {WIDTH{1'b0}};
                cnt_r   <= {CW{1'b0}};
            end else if (state_r == ST_RUN) begin
                opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
                opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
                carry_r <= slice_cout_s;
                acc_r   <= acc_next_s;
                if (last_bit_s) begin
                    // carry_r here is the carry into the MSB, so comparing it
                    // with the MSB carry-out gives signed overflow.
                    sum_r       <= acc_next_s;
                    carry_out_r <= slice_cout_s;
                    overflow_r  <= carry_r ^ slice_cout_s;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;

    serial_add_ctrl_chk #(.WIDTH(WIDTH)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .start    (bus.start),
        .accept   (accept_s),
        .a        (bus.a),
        .b        (bus.b),
        .carry_in (bus.carry_in)
    );
endmodule

// ---------------------------------------------------------------------------
// serial_add_ctrl_chk
// Simulation-only X checks on the request inputs of serial_add_ctrl.
//   start must always be 0/1; a, b and carry_in must be 0/1 on every accepted
//   start.
// ---------------------------------------------------------------------------
module serial_add_ctrl_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             start,
    input logic             accept,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             carry_in
);
    a_start_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(start))
        else $error("serial_add_ctrl: start is X/Z");

    a_operands_known: assert property (@(posedge clk) disable iff (rst)
        accept |-> !$isunknown({a, b, carry_in}))
        else $error("serial_add_ctrl: operand X/Z on accepted start");
endmodule
